carregador_programa: RTL
========================

# carregador_programa

Program loader for the iZero CPU: receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses. It is the writer side of the instruction-fetch path. It runs before the CPU is released, filling the same word-addressed space that the PC-indexed fetch later reads. A 16-bit word-count header precedes the payload, and completion or an error is reported through sticky status flags.

## Interface
- ADDR_WIDTH, 26, width of the instruction-memory word address (matches PC width)
- BASE_ADDR, 0, address of the first word written
- MAX_WORDS, 1024, largest word count accepted in the header
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled only in OCIOSO
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in holds a valid byte
- byte_ready  output  1  loader accepts a byte this cycle
- mem_addr  output  ADDR_WIDTH  instruction-memory write address
- mem_data  output  32  instruction word to write
- mem_we  output  1  write strobe, one cycle per word
- ocupado  output  1  load in progress
- concluido  output  1  sticky: last load completed
- erro  output  1  sticky: last load rejected (bad header)
- palavras_escritas  output  16  words written in the current or last load

## Operation
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Handshake: a byte is accepted at a rising edge where byte_valid && byte_ready. byte_valid may drop at any time. No byte is ever accepted twice.
- States and transitions:
  - OCIOSO: byte_ready=0. On start, clear concluido, erro and palavras_escritas, set ocupado=1, then go to CAB_ALTO.
  - CAB_ALTO: byte_ready=1. The accepted byte becomes N[15:8]. Go to CAB_BAIXO.
  - CAB_BAIXO: byte_ready=1. The accepted byte becomes N[7:0]. Go to VALIDA.
  - VALIDA (1 cycle, byte_ready=0):
    - If N==0 or N>MAX_WORDS: set erro=1, ocupado=0, go to OCIOSO.
    - Otherwise: load word index 0 and byte counter 0, go to DADOS.
  - DADOS: byte_ready=1. Bytes shift into the word register MSB-first: the first byte becomes bits [31:24] and the fourth becomes bits [7:0]. On the 4th accepted byte, go to ESCREVE.
  - ESCREVE (1 cycle, byte_ready=0):
    - mem_we=1, mem_addr=BASE_ADDR+index, mem_data=the assembled word.
    - palavras_escritas increments.
    - If index==N-1, go to FIM; else increment index and go to DADOS.
  - FIM (1 cycle): concluido=1, ocupado=0, go to OCIOSO.
- Address arithmetic is modulo 2^ADDR_WIDTH. The index is 16 bits wide. N is compared unsigned.
- start is ignored in every state except OCIOSO.
- Bytes presented while byte_ready=0 are not consumed.
- concluido and erro hold until the next accepted start or reset. They are never both 1.
- Reset in any state:
  - Returns to OCIOSO.
  - Discards any partial word and issues no write.
  - Reset wins over start and over byte acceptance in the same cycle.
- Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, ocupado=0, concluido=0, erro=0, palavras_escritas=0.
- mem_addr and mem_data hold their last values outside ESCREVE. Only mem_we qualifies them.

## Timing
- start sampled at edge t: ocupado=1 and byte_ready=1 from cycle t+1.
- Second header byte accepted at edge h: VALIDA runs in cycle h+1. erro (if set) is visible, or DADOS is entered, from cycle h+2.
- Fourth byte of a word accepted at edge k: mem_we=1 during cycle k+1 only. byte_ready returns to 1 in cycle k+2.
- Peak throughput is one word per 5 cycles.
- Last write in cycle w: concluido=1 and ocupado=0 from cycle w+2.
- Minimum load time with byte_valid held high: 1 (start) + 2 (header) + 1 (VALIDA) + 5N + 1 (FIM) cycles.

## Test plan
- N=2, byte stream 00 02 58 00 00 01 04 21 00 01 with byte_valid held high:
  - Writes 0x58000001 @0, then 0x04210001 @1.
  - Exactly two mem_we pulses.
  - Ends with palavras_escritas=2, concluido=1, erro=0.
- Same stream with byte_valid deasserted every other cycle: identical writes and final state, no duplicated bytes, no extra mem_we.
- Header 00 00:
  - erro=1, ocupado=0, no mem_we.
  - byte_ready stays 0 afterwards.
  - A following start clears erro.
- Header equal to MAX_WORDS+1 (04 01 at default): erro=1, no writes. Header 04 00 is accepted.
- Reset asserted after 2 payload bytes of word 0:
  - No mem_we; all outputs return to reset values.
  - A new start with N=1, bytes 00 01 60 00 00 00, writes 0x60000000 @BASE_ADDR.
- start pulsed during DADOS: ignored. The load completes normally and palavras_escritas is not cleared.

Source files
------------

// File: rtl/carregador_programa.sv
// Program loader: byte stream -> big-endian 32-bit words -> instruction memory.
// Ports: clock/reset, start, byte_in/byte_valid/byte_ready, mem_addr/mem_data/mem_we, ocupado/concluido/erro, palavras_escritas.
module carregador_programa #(
   parameter int unsigned ADDR_WIDTH = 26,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned MAX_WORDS  = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_data,
   output logic                  mem_we,
   output logic                  ocupado,
   output logic                  concluido,
   output logic                  erro,
   output logic [15:0]           palavras_escritas
);

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {
      OCIOSO,
      CAB_ALTO,
      CAB_BAIXO,
      VALIDA,
      DADOS,
      ESCREVE,
      FIM
   } estado_t;

   estado_t estado_q, estado_d;

   logic [15:0]           n_q, n_d;
   logic [15:0]           idx_q, idx_d;
   logic [15:0]           pal_q, pal_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [31:0]           word_q, word_d;
   logic [31:0]           data_q, data_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  ready_q, ready_d;
   logic                  we_q, we_d;
   logic                  ocup_q, ocup_d;
   logic                  conc_q, conc_d;
   logic                  erro_q, erro_d;
   logic                  aceita;

   // byte_ready is a register, so acceptance uses its registered value
   assign aceita = byte_valid && ready_q;

   always_comb begin
      estado_d = estado_q;
      n_d      = n_q;
      idx_d    = idx_q;
      pal_d    = pal_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      data_d   = data_q;
      addr_d   = addr_q;
      we_d     = 1'b0;
      ocup_d   = ocup_q;
      conc_d   = conc_q;
      erro_d   = erro_q;

      unique case (estado_q)
         OCIOSO: begin
            if (start) begin
               conc_d   = 1'b0;
               erro_d   = 1'b0;
               pal_d    = 16'd0;
               ocup_d   = 1'b1;
               estado_d = CAB_ALTO;
            end
         end
         CAB_ALTO: begin
            if (aceita) begin
               n_d      = {byte_in, n_q[7:0]};
               estado_d = CAB_BAIXO;
            end
         end
         CAB_BAIXO: begin
            if (aceita) begin
               n_d      = {n_q[15:8], byte_in};
               estado_d = VALIDA;
            end
         end
         VALIDA: begin
            if (n_q == 16'd0 || {16'd0, n_q} > MAX_WORDS) begin
               erro_d   = 1'b1;
               ocup_d   = 1'b0;
               estado_d = OCIOSO;
            end else begin
               idx_d    = 16'd0;
               cnt_d    = 2'd0;
               estado_d = DADOS;
            end
         end
         DADOS: begin
            if (aceita) begin
               word_d = {word_q[23:0], byte_in};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  // write strobe and bus are registered on entry to ESCREVE
                  we_d     = 1'b1;
                  addr_d   = BASE + ADDR_WIDTH'(idx_q);
                  data_d   = {word_q[23:0], byte_in};
                  estado_d = ESCREVE;
               end
            end
         end
         ESCREVE: begin
            pal_d = pal_q + 16'd1;
            if (idx_q == n_q - 16'd1) begin
               estado_d = FIM;
            end else begin
               idx_d    = idx_q + 16'd1;
               estado_d = DADOS;
            end
         end
         FIM: begin
            conc_d   = 1'b1;
            ocup_d   = 1'b0;
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
            ocup_d   = 1'b0;
         end
      endcase

      ready_d = (estado_d == CAB_ALTO) ||
                (estado_d == CAB_BAIXO) ||
                (estado_d == DADOS);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= OCIOSO;
         n_q      <= 16'd0;
         idx_q    <= 16'd0;
         pal_q    <= 16'd0;
         cnt_q    <= 2'd0;
         word_q   <= 32'd0;
         data_q   <= 32'd0;
         addr_q   <= BASE;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         ocup_q   <= 1'b0;
         conc_q   <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         n_q      <= n_d;
         idx_q    <= idx_d;
         pal_q    <= pal_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         ready_q  <= ready_d;
         we_q     <= we_d;
         ocup_q   <= ocup_d;
         conc_q   <= conc_d;
         erro_q   <= erro_d;
      end
   end

   assign byte_ready        = ready_q;
   assign mem_addr          = addr_q;
   assign mem_data          = data_q;
   assign mem_we            = we_q;
   assign ocupado           = ocup_q;
   assign concluido         = conc_q;
   assign erro              = erro_q;
   assign palavras_escritas = pal_q;

endmodule
